activation_padder: RTL and testbench

- Upstream stage of the convolution layer. Takes a raw row-major activation stream of S×S values and emits a padded stream of (S+2p)×(S+2p) values.
- The border is filled with a programmable pad value.
- Its output valid drives the convolution layer's run enable, so padding is applied in-stream with no RAM.
- Each frame is started by start_i with a matrix size and padding amount, and flow control is handshaked on both sides.

---
 rtl/activation_padder_if.sv | 32 +++
 rtl/activation_padder.sv | 177 +++++++++++++++++
 tb/tb_activation_padder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/activation_padder_if.sv
// Handshake/config bundle between the activation padder and its neighbours.
// The padder connects to the slave modport; the stimulus side uses master.
interface activation_padder_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned PW = 4
);
  logic                start_i;
  logic [13:0]         matrix_size_i;
  logic [PW-1:0]       padding_i;
  logic signed [N-1:0] pad_value_i;
  logic signed [N-1:0] data_i;
  logic                data_valid_i;
  logic                data_ready_o;
  logic signed [N-1:0] data_o;
  logic                valid_o;
  logic                ready_i;
  logic                busy_o;
  logic                done_o;
  logic                err_o;

  modport slave (
    input  start_i, matrix_size_i, padding_i, pad_value_i,
    input  data_i, data_valid_i, ready_i,
    output data_ready_o, data_o, valid_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, matrix_size_i, padding_i, pad_value_i,
    output data_i, data_valid_i, ready_i,
    input  data_ready_o, data_o, valid_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/activation_padder.sv
// Streams an S x S activation frame out as a (S+2p) x (S+2p) frame with a
// programmable border value, inserting pad beats in-stream without storage.
module activation_padder #(
  parameter int unsigned MaxMatrixSize = 16383,
  parameter int unsigned MaxPadding    = 15,
  parameter int unsigned N             = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  activation_padder_if.slave bus
);

  localparam int unsigned PW = $clog2(MaxPadding + 1);
  localparam int unsigned SW = 14;
  localparam int unsigned WP = $clog2(MaxMatrixSize + 2 * MaxPadding + 1);
  // Config check width: wide enough that S + 2p never wraps whatever WP is.
  localparam int unsigned CW = (WP > SW + 1) ? WP : SW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [WP-1:0]       r_row, w_row_nxt;
  logic [WP-1:0]       r_col, w_col_nxt;
  logic [WP-1:0]       r_size, w_size_nxt;
  logic [WP-1:0]       r_psize, w_psize_nxt;
  logic [PW-1:0]       r_pad, w_pad_nxt;
  logic signed [N-1:0] r_pad_val, w_pad_val_nxt;
  logic signed [N-1:0] r_data, w_data_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_last, w_last_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;

  logic [CW-1:0]       w_p_calc;
  logic [CW-1:0]       w_pad_ext;
  logic                w_cfg_bad;
  logic [WP-1:0]       w_pad_wp;
  logic [WP-1:0]       w_hi;
  logic                w_interior;
  logic                w_adv;
  logic                w_col_end;
  logic                w_row_end;
  logic                w_load;
  logic signed [N-1:0] w_load_data;
  logic                w_data_ready;

  assign w_pad_ext = CW'(bus.padding_i);
  assign w_p_calc  = CW'(bus.matrix_size_i) + (w_pad_ext << 1);
  assign w_cfg_bad = (w_p_calc > CW'(MaxMatrixSize)) || (w_pad_ext > CW'(MaxPadding));

  // Position classification against the latched frame geometry.
  assign w_pad_wp   = WP'(r_pad);
  assign w_hi       = w_pad_wp + r_size;
  assign w_interior = (r_row >= w_pad_wp) && (r_row < w_hi) &&
                      (r_col >= w_pad_wp) && (r_col < w_hi);
  assign w_adv      = !r_valid || bus.ready_i;
  assign w_col_end  = (r_col == r_psize - WP'(1));
  assign w_row_end  = (r_row == r_psize - WP'(1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_size    <= '0;
      r_psize   <= '0;
      r_pad     <= '0;
      r_pad_val <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_size    <= w_size_nxt;
      r_psize   <= w_psize_nxt;
      r_pad     <= w_pad_nxt;
      r_pad_val <= w_pad_val_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_last    <= w_last_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_size_nxt    = r_size;
    w_psize_nxt   = r_psize;
    w_pad_nxt     = r_pad;
    w_pad_val_nxt = r_pad_val;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_last_nxt    = r_last;
    w_err_nxt     = 1'b0;
    w_data_ready  = 1'b0;
    w_load        = 1'b0;
    w_load_data   = r_pad_val;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          if (w_cfg_bad) begin
            w_err_nxt = 1'b1;
          end else if (w_p_calc == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_size_nxt    = WP'(bus.matrix_size_i);
            w_psize_nxt   = WP'(w_p_calc);
            w_pad_nxt     = PW'(bus.padding_i);
            w_pad_val_nxt = bus.pad_value_i;
            w_row_nxt     = '0;
            w_col_nxt     = '0;
            w_last_nxt    = 1'b0;
            w_state_nxt   = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Once the final beat is loaded, only its transfer matters.
        if (r_last) begin
          if (r_valid && bus.ready_i) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = S_DONE;
          end
        end else if (w_adv) begin
          if (!w_interior) begin
            w_load      = 1'b1;
            w_load_data = r_pad_val;
          end else begin
            w_data_ready = 1'b1;
            if (bus.data_valid_i) begin
              w_load      = 1'b1;
              w_load_data = bus.data_i;
            end else begin
              w_valid_nxt = 1'b0;
            end
          end
        end

        if (w_load) begin
          w_data_nxt  = w_load_data;
          w_valid_nxt = 1'b1;
          w_last_nxt  = w_col_end && w_row_end;
          if (w_col_end) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + WP'(1);
          end else begin
            w_col_nxt = r_col + WP'(1);
          end
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign bus.data_ready_o = w_data_ready;
  assign bus.data_o       = r_data;
  assign bus.valid_o      = r_valid;
  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.err_o        = r_err;

endmodule

// File: tb/tb_activation_padder.sv
// Randomised bench for activation_padder: frames are driven with random
// handshakes and the output stream is compared against a padded-matrix model.
module tb_activation_padder;

  localparam int unsigned N    = 8;
  localparam int unsigned MAXM = 10;
  localparam int unsigned MAXP = 15;
  localparam int unsigned PW   = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  activation_padder_if #(.N(N), .PW(PW)) bus();

  activation_padder #(.MaxMatrixSize(MAXM), .MaxPadding(MAXP), .N(N)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic signed [N-1:0] in_q[$];
  logic signed [N-1:0] got_q[$];
  logic signed [N-1:0] exp_q[$];

  int n_consumed, done_cnt, done_cyc, first_xfer_cyc, last_xfer_cyc;
  int err_cnt, valid_cnt, busy_seen, busy_bad, hold_bad;
  bit timed_out, abort_zero;

  // Reference: padded matrix built directly from the geometry rules.
  function automatic void build_expected(input int s, input int p, input logic signed [N-1:0] pad);
    int pp;
    pp = s + 2 * p;
    exp_q.delete();
    for (int r = 0; r < pp; r++)
      for (int c = 0; c < pp; c++)
        if (r >= p && r < p + s && c >= p && c < p + s) exp_q.push_back(in_q[(r - p) * s + (c - p)]);
        else exp_q.push_back(pad);
  endfunction

  function automatic void fill_inputs(input int cnt, input bit rnd);
    in_q.delete();
    for (int i = 0; i < cnt; i++) in_q.push_back(rnd ? N'($urandom) : N'(i + 1));
  endfunction

  task automatic run_frame(input int s, input int p, input logic signed [N-1:0] pad,
                           input int rdy_pct, input int vld_pct, input int abort_at, input int max_cyc);
    int idx, extra, after, total;
    bit prev_hold, stopped;
    logic signed [N-1:0] prev_data;
    idx = 0; extra = 0; after = 0; prev_hold = 0; prev_data = '0; stopped = 0;
    total = (s + 2 * p) * (s + 2 * p);
    done_cnt = 0; done_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
    err_cnt = 0; valid_cnt = 0; busy_seen = 0; busy_bad = 0; hold_bad = 0; abort_zero = 0;
    got_q.delete();
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.matrix_size_i = 14'(s);
    bus.padding_i = PW'(p);
    bus.pad_value_i = pad;
    bus.data_valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk_i);
      bus.start_i      = 1'b0;
      bus.ready_i      = ($urandom_range(0, 99) < rdy_pct);
      bus.data_valid_i = ($urandom_range(0, 99) < vld_pct);
      bus.data_i       = (idx < in_q.size()) ? in_q[idx] : N'($urandom);
      #1;
      if (bus.done_o) begin done_cnt++; done_cyc = cyc; end
      if (bus.err_o) err_cnt++;
      if (bus.valid_o) valid_cnt++;
      if (bus.busy_o) busy_seen++;
      if (done_cnt == 0 && got_q.size() < total && !bus.busy_o) busy_bad++;
      if (prev_hold && (!bus.valid_o || bus.data_o !== prev_data)) hold_bad++;
      prev_hold = bus.valid_o && !bus.ready_i;
      prev_data = bus.data_o;
      if (bus.valid_o && bus.ready_i) begin
        if (got_q.size() == 0) first_xfer_cyc = cyc;
        got_q.push_back(bus.data_o);
        last_xfer_cyc = cyc;
      end
      if (bus.data_ready_o && bus.data_valid_i) begin
        if (idx < in_q.size()) idx++;
        else extra++;
      end
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        #1 rst_i = 1'b0;
        #1 abort_zero = (bus.valid_o === 1'b0) && (bus.data_o === '0) && (bus.busy_o === 1'b0) &&
                        (bus.done_o === 1'b0) && (bus.err_o === 1'b0) && (bus.data_ready_o === 1'b0);
        stopped = 1;
        break;
      end
      if (done_cnt > 0 || err_cnt > 0) after++;
      if (after >= 3) begin stopped = 1; break; end
    end
    timed_out = !stopped;
    n_consumed = idx + extra;
    bus.data_valid_i = 1'b0;
    bus.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== '0) begin
      failures++; $display("FAIL reset_data valid=%b data=%0d want 0/0", bus.valid_o, bus.data_o);
    end
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.err_o !== 1'b0 || bus.data_ready_o !== 1'b0) begin
      failures++; $display("FAIL reset_status busy=%b done=%b err=%b rdy=%b want 0", bus.busy_o, bus.done_o, bus.err_o, bus.data_ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_pad_basic();
    fill_inputs(9, 0);
    build_expected(3, 1, '0);
    run_frame(3, 1, '0, 100, 100, -1, 200);
    checks++;
    if (got_q.size() != 25 || timed_out) begin
      failures++; $display("FAIL basic_count got=%0d want=25 timeout=%0b", got_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL basic_beat[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_xfer_cyc + 1) begin
      failures++; $display("FAIL basic_done pulses=%0d at=%0d want 1 at %0d", done_cnt, done_cyc, last_xfer_cyc + 1);
    end
    checks++;
    if (busy_bad != 0 || n_consumed != 9) begin
      failures++; $display("FAIL basic_busy_consume busy_low=%0d consumed=%0d want 0/9", busy_bad, n_consumed);
    end
  endtask

  task automatic test_passthrough();
    in_q.delete();
    for (int i = 0; i < 25; i++) in_q.push_back(N'(i));
    build_expected(5, 0, N'(7));
    run_frame(5, 0, N'(7), 100, 100, -1, 200);
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL pass_beat[%0d] got=%0d want=%0d", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    checks++;
    if (first_xfer_cyc != 1 || last_xfer_cyc - first_xfer_cyc != 24) begin
      failures++; $display("FAIL pass_timing first=%0d span=%0d want 1/24", first_xfer_cyc, last_xfer_cyc - first_xfer_cyc);
    end
    checks++;
    if (n_consumed != 25 || got_q.size() != 25) begin
      failures++; $display("FAIL pass_counts consumed=%0d beats=%0d want 25/25", n_consumed, got_q.size());
    end
  endtask

  task automatic test_neg_pad();
    fill_inputs(4, 1);
    build_expected(2, 2, -8'sd3);
    run_frame(2, 2, -8'sd3, 80, 70, -1, 500);
    checks++;
    if (got_q.size() != 36 || n_consumed != 4) begin
      failures++; $display("FAIL negpad_counts beats=%0d consumed=%0d want 36/4", got_q.size(), n_consumed);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL negpad_beat[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    fill_inputs(9, 0);
    build_expected(3, 1, '0);
    for (int k = 0; k < 3; k++) begin
      run_frame(3, 1, '0, 50, 50, -1, 2000);
      checks++;
      if (got_q.size() != 25 || n_consumed != 9 || done_cnt != 1) begin
        failures++; $display("FAIL bp_counts run=%0d beats=%0d consumed=%0d done=%0d want 25/9/1", k, got_q.size(), n_consumed, done_cnt);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL bp_beat[%0d] run=%0d got=%0d want=%0d", i, k, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (hold_bad != 0) begin
        failures++; $display("FAIL bp_hold run=%0d unstable=%0d want 0", k, hold_bad);
      end
    end
  endtask

  task automatic test_config_err();
    fill_inputs(81, 1);
    run_frame(9, 1, '0, 100, 100, -1, 20);
    checks++;
    if (err_cnt != 1 || valid_cnt != 0 || busy_seen != 0 || done_cnt != 0) begin
      failures++; $display("FAIL cfg_err err=%0d valid=%0d busy=%0d done=%0d want 1/0/0/0", err_cnt, valid_cnt, busy_seen, done_cnt);
    end
    fill_inputs(64, 1);
    build_expected(8, 1, N'(5));
    run_frame(8, 1, N'(5), 70, 70, -1, 2000);
    checks++;
    if (got_q.size() != 100 || err_cnt != 0 || done_cnt != 1) begin
      failures++; $display("FAIL cfg_ok beats=%0d err=%0d done=%0d want 100/0/1", got_q.size(), err_cnt, done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL cfg_ok_beat[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_size();
    in_q.delete();
    build_expected(0, 2, N'(9));
    run_frame(0, 2, N'(9), 100, 100, -1, 200);
    checks++;
    if (got_q.size() != 16 || n_consumed != 0 || done_cnt != 1) begin
      failures++; $display("FAIL zero_s beats=%0d consumed=%0d done=%0d want 16/0/1", got_q.size(), n_consumed, done_cnt);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL zero_s_beat[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]);
      end
    end
    run_frame(0, 0, N'(9), 100, 100, -1, 20);
    checks++;
    if (done_cnt != 1 || valid_cnt != 0 || err_cnt != 0 || done_cyc != 0) begin
      failures++; $display("FAIL empty_frame done=%0d at=%0d valid=%0d err=%0d want 1/0/0/0", done_cnt, done_cyc, valid_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int done_after;
    fill_inputs(9, 0);
    build_expected(3, 1, '0);
    run_frame(3, 1, '0, 100, 100, 12, 200);
    checks++;
    if (!abort_zero || got_q.size() != 12) begin
      failures++; $display("FAIL abort_outputs zero=%0b beats=%0d want 1/12", abort_zero, got_q.size());
    end
    done_after = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (bus.done_o || bus.busy_o || bus.valid_o) done_after++;
    end
    checks++;
    if (done_after != 0) begin
      failures++; $display("FAIL abort_quiet activity=%0d want 0", done_after);
    end
    run_frame(3, 1, '0, 100, 100, -1, 200);
    checks++;
    if (got_q.size() != 25 || done_cnt != 1) begin
      failures++; $display("FAIL abort_restart beats=%0d done=%0d want 25/1", got_q.size(), done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL abort_restart_beat[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.start_i       = 1'b0;
    bus.matrix_size_i = '0;
    bus.padding_i     = '0;
    bus.pad_value_i   = '0;
    bus.data_i        = '0;
    bus.data_valid_i  = 1'b0;
    bus.ready_i       = 1'b0;
    test_reset();
    test_pad_basic();
    test_passthrough();
    test_neg_pad();
    test_backpressure();
    test_config_err();
    test_zero_size();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
